// File: rtl/processor_to_uart_wr_ctrl.sv
// Write-side pointer/flag controller of the processor-to-UART async FIFO.
// Owns the binary/Gray write pointer and derives full/level from a 2-flop synchronized read pointer.
module processor_to_uart_wr_ctrl #(
    parameter int ADDR_WIDTH = 4,
    parameter int AF_LEVEL   = 12
) (
    input  logic                  processor_clk,
    input  logic                  reset,
    input  logic                  push,
    input  logic                  overflow_clr,
    input  logic [ADDR_WIDTH:0]   r_ptr_gray,
    output logic [ADDR_WIDTH-1:0] w_add,
    output logic                  mem_we,
    output logic [ADDR_WIDTH:0]   w_ptr_gray,
    output logic                  full,
    output logic                  almost_full,
    output logic [ADDR_WIDTH:0]   level,
    output logic                  overflow
);
    localparam int PW = ADDR_WIDTH + 1;
    localparam logic [PW-1:0] AF_V = PW'(AF_LEVEL);

    logic [PW-1:0] r_w_ptr;
    logic [PW-1:0] r_w_ptr_gray;
    logic [PW-1:0] r_s1;
    logic [PW-1:0] r_s2;
    logic          r_overflow;

    logic [PW-1:0] w_r_sync;
    logic [PW-1:0] w_level;
    logic [PW-1:0] w_ptr_inc;
    logic          w_full;
    logic          w_we;

    // Gray-to-binary: each binary bit is the XOR of all Gray bits at or above it.
    genvar gi;
    generate
        for (gi = 0; gi < PW; gi++) begin : g_gray2bin
            assign w_r_sync[gi] = ^r_s2[PW-1:gi];
        end
    endgenerate

    assign w_level   = r_w_ptr - w_r_sync;
    assign w_full    = (r_w_ptr[PW-1] != w_r_sync[PW-1]) &&
                       (r_w_ptr[ADDR_WIDTH-1:0] == w_r_sync[ADDR_WIDTH-1:0]);
    assign w_we      = push & ~w_full & ~reset;
    assign w_ptr_inc = r_w_ptr + PW'(1);

    always_ff @(posedge processor_clk) begin
        if (reset) begin
            r_w_ptr      <= '0;
            r_w_ptr_gray <= '0;
            r_s1         <= '0;
            r_s2         <= '0;
            r_overflow   <= 1'b0;
        end else begin
            r_s1 <= r_ptr_gray;
            r_s2 <= r_s1;
            if (w_we) begin
                r_w_ptr      <= w_ptr_inc;
                r_w_ptr_gray <= w_ptr_inc ^ (w_ptr_inc >> 1);
            end
            // A rejected push outranks a simultaneous clear.
            if (push && w_full)
                r_overflow <= 1'b1;
            else if (overflow_clr)
                r_overflow <= 1'b0;
        end
    end

    assign w_add       = r_w_ptr[ADDR_WIDTH-1:0];
    assign mem_we      = w_we;
    assign w_ptr_gray  = r_w_ptr_gray;
    assign full        = w_full;
    assign almost_full = (w_level >= AF_V);
    assign level       = w_level;
    assign overflow    = r_overflow;
endmodule

// File: tb/tb_processor_to_uart_wr_ctrl.sv
// Self-checking bench: directed scenarios plus randomized push/read traffic against a
// occupancy-count model (writes accepted minus read pointer seen two edges late).
module tb_processor_to_uart_wr_ctrl;
    localparam int AW    = 4;
    localparam int DEPTH = 16;
    localparam int AFL   = 12;

    logic          processor_clk = 1'b0;
    logic          reset = 1'b0;
    logic          push = 1'b0;
    logic          overflow_clr = 1'b0;
    logic [AW:0]   rb = '0;
    logic [AW:0]   r_ptr_gray;
    logic [AW-1:0] w_add;
    logic          mem_we;
    logic [AW:0]   w_ptr_gray;
    logic          full;
    logic          almost_full;
    logic [AW:0]   level;
    logic          overflow;

    int  n_cmp = 0;
    int  n_bad = 0;
    bit  chk_en = 1'b0;

    int  m_wp = 0;
    int  m_s1 = 0;
    int  m_s2 = 0;
    bit  m_ovf = 1'b0;

    assign r_ptr_gray = rb ^ (rb >> 1);

    processor_to_uart_wr_ctrl #(.ADDR_WIDTH(AW), .AF_LEVEL(AFL)) dut (
        .processor_clk(processor_clk),
        .reset(reset),
        .push(push),
        .overflow_clr(overflow_clr),
        .r_ptr_gray(r_ptr_gray),
        .w_add(w_add),
        .mem_we(mem_we),
        .w_ptr_gray(w_ptr_gray),
        .full(full),
        .almost_full(almost_full),
        .level(level),
        .overflow(overflow)
    );

    always #5 processor_clk = ~processor_clk;

    function automatic int m_lvl();
        return (m_wp - m_s2) & 31;
    endfunction

    task automatic check(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference: writer count advances when a push meets a non-full view; the read
    // pointer becomes visible two edges after it is presented.
    always @(posedge processor_clk) begin
        bit f;
        f = (m_lvl() == DEPTH);
        if (reset) begin
            m_wp = 0; m_s1 = 0; m_s2 = 0; m_ovf = 1'b0;
        end else begin
            if (push && !f) m_wp = (m_wp + 1) % 32;
            if (push && f) m_ovf = 1'b1;
            else if (overflow_clr) m_ovf = 1'b0;
            m_s2 = m_s1;
            m_s1 = int'(rb);
        end
    end

    always @(negedge processor_clk) begin
        if (chk_en) begin
            int lv;
            #1;
            lv = m_lvl();
            check("level",       int'(level),       lv);
            check("full",        int'(full),        int'(lv == DEPTH));
            check("almost_full", int'(almost_full), int'(lv >= AFL));
            check("w_add",       int'(w_add),       m_wp % DEPTH);
            check("w_ptr_gray",  int'(w_ptr_gray),  m_wp ^ (m_wp >> 1));
            check("overflow",    int'(overflow),    int'(m_ovf));
            check("mem_we",      int'(mem_we),      int'(push && lv != DEPTH && !reset));
        end
    end

    task automatic cyc(input bit p, input bit c, input bit rst, input int r);
        @(negedge processor_clk);
        push = p; overflow_clr = c; reset = rst; rb = 5'(r);
        @(posedge processor_clk);
        #1;
    endtask

    initial begin
        int r;
        // 1: reset with push held high
        repeat (2) begin
            @(negedge processor_clk);
            push = 1'b1; reset = 1'b1; rb = '0;
            #1;
            check("rst_mem_we", int'(mem_we), 0);
            @(posedge processor_clk);
        end
        #1;
        check("rst_w_add", int'(w_add), 0);
        check("rst_gray", int'(w_ptr_gray), 0);
        check("rst_level", int'(level), 0);
        chk_en = 1'b1;

        // 2: fill from empty
        for (int i = 1; i <= 16; i++) begin
            cyc(1, 0, 0, 0);
            if (i == 11) check("af_before12", int'(almost_full), 0);
            if (i == 12) check("af_at12", int'(almost_full), 1);
        end
        check("fill_full", int'(full), 1);
        check("fill_level", int'(level), 16);
        check("fill_gray", int'(w_ptr_gray), 5'b11000);

        // 3: overflow set/clear priority
        cyc(1, 0, 0, 0);
        check("ovf_set", int'(overflow), 1);
        check("ovf_w_add", int'(w_add), 0);
        cyc(0, 1, 0, 0);
        check("ovf_clr", int'(overflow), 0);
        cyc(1, 1, 0, 0);
        check("ovf_set_wins", int'(overflow), 1);
        cyc(0, 1, 0, 0);

        // 4: one read, seen after two edges
        cyc(0, 0, 0, 1);
        check("sync_edge1_full", int'(full), 1);
        cyc(0, 0, 0, 1);
        check("sync_edge2_full", int'(full), 0);
        check("sync_edge2_level", int'(level), 15);
        cyc(1, 0, 0, 1);
        check("refill_level", int'(level), 16);

        // 5: reader advances to 16, writer wraps to 0
        for (int i = 2; i <= 16; i++) cyc(0, 0, 0, i);
        cyc(0, 0, 0, 16);
        cyc(0, 0, 0, 16);
        check("wrap_start_level", int'(level), 1);
        for (int i = 1; i <= 15; i++) begin
            cyc(1, 0, 0, 16);
            if (i == 14) check("wrap_gray31", int'(w_ptr_gray), 5'b10000);
        end
        check("wrap_gray0", int'(w_ptr_gray), 0);
        check("wrap_full", int'(full), 1);
        check("wrap_level", int'(level), 16);

        // 6: mid-stream reset with push
        for (int i = 17; i <= 24; i++) cyc(0, 0, 0, i);
        cyc(0, 0, 0, 24);
        cyc(0, 0, 0, 24);
        repeat (5) cyc(1, 0, 0, 24);
        check("pre_rst_level", int'(level), 13);
        cyc(1, 0, 1, 24);
        check("mid_rst_w_add", int'(w_add), 0);
        check("mid_rst_level", int'(level), 0);
        check("mid_rst_full", int'(full), 0);
        check("mid_rst_gray", int'(w_ptr_gray), 0);
        cyc(0, 0, 0, 24);
        check("reload_edge1", int'(level), 0);
        cyc(0, 0, 0, 24);
        check("reload_edge2", int'(level), 8);
        cyc(0, 0, 1, 0);
        cyc(0, 0, 0, 0);

        // Random traffic; reader never passes the writer, occasional joint reset.
        r = 0;
        for (int i = 0; i < 4000; i++) begin
            int pb, rdb;
            bit p, c, rst;
            pb  = (i / 500) % 2 ? 3 : 1;
            rdb = (i / 500) % 2 ? 1 : 3;
            p   = ($urandom_range(0, 3) < pb);
            c   = ($urandom_range(0, 7) == 0);
            rst = ($urandom_range(0, 599) == 0);
            if (rst) r = 0;
            else if (((m_wp - r) & 31) != 0 && $urandom_range(0, 3) < rdb) r = (r + 1) % 32;
            cyc(p, c, rst, r);
        end
        cyc(0, 0, 0, r);
        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
